// File: rtl/regs_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regs_wb_arbiter
// Brief    : Round-robin share of the regfile write port between ex and mc,
//            plus a pending scoreboard of mc destinations for decode hazards.
// Revision : 1.0
// ============================================================================
module regs_wb_arbiter #(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ex_wvalid_i,
    output logic          ex_wready_o,
    input  logic [AW-1:0] ex_waddr_i,
    input  logic [DW-1:0] ex_wdata_i,
    input  logic          mc_wvalid_i,
    output logic          mc_wready_o,
    input  logic [AW-1:0] mc_waddr_i,
    input  logic [DW-1:0] mc_wdata_i,
    input  logic          mc_issue_i,
    input  logic [AW-1:0] mc_issue_rd_i,
    input  logic [AW-1:0] id_rs1_i,
    input  logic [AW-1:0] id_rs2_i,
    input  logic [AW-1:0] id_rd_i,
    output logic          hazard_o,
    output logic [AW-1:0] reg_waddr_o,
    output logic [DW-1:0] reg_wdata_o,
    output logic          reg_wen_o
);

    localparam int   c_NREG     = 1 << AW;
    localparam logic c_GRANT_EX = 1'b0;
    localparam logic c_GRANT_MC = 1'b1;

    logic              r_last_grant;
    logic [c_NREG-1:0] r_pending;
    logic [c_NREG-1:0] w_pending_nxt;
    logic              w_ex_grant;
    logic              w_mc_grant;
    logic              w_contend;

    // Grants depend only on the valids and last_grant, never on request data.
    always_comb begin
        w_contend  = ex_wvalid_i && mc_wvalid_i;
        w_ex_grant = ex_wvalid_i && (!mc_wvalid_i || (r_last_grant == c_GRANT_MC));
        w_mc_grant = mc_wvalid_i && (!ex_wvalid_i || (r_last_grant == c_GRANT_EX));
    end

    assign ex_wready_o = w_ex_grant;
    assign mc_wready_o = w_mc_grant;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_last_grant <= c_GRANT_MC;
        end else if (w_contend) begin
            r_last_grant <= w_ex_grant ? c_GRANT_EX : c_GRANT_MC;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            reg_wen_o   <= 1'b0;
            reg_waddr_o <= '0;
            reg_wdata_o <= '0;
        end else if (w_ex_grant) begin
            reg_wen_o   <= (ex_waddr_i != '0);
            reg_waddr_o <= ex_waddr_i;
            reg_wdata_o <= ex_wdata_i;
        end else if (w_mc_grant) begin
            reg_wen_o   <= (mc_waddr_i != '0);
            reg_waddr_o <= mc_waddr_i;
            reg_wdata_o <= mc_wdata_i;
        end else begin
            reg_wen_o   <= 1'b0;
        end
    end

    // Clear first so a same-cycle issue to the same rd leaves the bit set.
    always_comb begin
        w_pending_nxt = r_pending;
        if (w_mc_grant) begin
            w_pending_nxt[mc_waddr_i] = 1'b0;
        end
        if (mc_issue_i && (mc_issue_rd_i != '0)) begin
            w_pending_nxt[mc_issue_rd_i] = 1'b1;
        end
        w_pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pending <= '0;
        end else begin
            r_pending <= w_pending_nxt;
        end
    end

    assign hazard_o = rst && (
                        ((id_rs1_i != '0) && r_pending[id_rs1_i]) ||
                        ((id_rs2_i != '0) && r_pending[id_rs2_i]) ||
                        ((id_rd_i  != '0) && r_pending[id_rd_i]));

endmodule
`default_nettype wire

// File: doc/regs_wb_arbiter.md
Name: regs_wb_arbiter

Overview:
- Shares the single register-file write port between two producers:
  - the single-cycle execute stage (ex);
  - a multi-cycle unit (mc: load/mul/div).
- Each producer uses a valid/ready handshake.
- Keeps a per-register pending scoreboard of outstanding mc destinations and raises a hazard to decode on RAW/WAW conflicts.
- Sits between ex/mc and the register file; drives the regfile write-port inputs.

Parameters:
- DW, 32, write data width
- AW, 5, register address width (32 registers, x0 hardwired zero)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- ex_wvalid_i  in  1  ex has a writeback pending
- ex_wready_o  out  1  ex writeback accepted this cycle
- ex_waddr_i  in  AW  ex destination register
- ex_wdata_i  in  DW  ex writeback data
- mc_wvalid_i  in  1  mc has a writeback pending
- mc_wready_o  out  1  mc writeback accepted this cycle
- mc_waddr_i  in  AW  mc destination register
- mc_wdata_i  in  DW  mc writeback data
- mc_issue_i  in  1  decode issues an instruction to mc this cycle
- mc_issue_rd_i  in  AW  destination of the issued mc instruction
- id_rs1_i  in  AW  decode source 1 address
- id_rs2_i  in  AW  decode source 2 address
- id_rd_i  in  AW  decode destination address
- hazard_o  out  1  decode must stall
- reg_waddr_o  out  AW  to regfile write address
- reg_wdata_o  out  DW  to regfile write data
- reg_wen_o  out  1  to regfile write enable

Behaviour:
- Reset (rst==0 at posedge clk):
  - reg_wen_o=0, reg_waddr_o=0, reg_wdata_o=0.
  - pending[31:0]=0.
  - last_grant=MC, so ex wins the first contention.
  - Reset mid-operation discards any in-flight grant; no write occurs the following cycle.
- Handshake:
  - A transfer occurs when valid && ready in the same cycle.
  - ready is combinational from the valids and last_grant; it never depends on its own requester's data.
  - Requesters hold valid/addr/data stable until accepted.
- Arbitration (round-robin, 2 requesters):
  - Only ex valid: ex_wready_o=1, mc_wready_o=0.
  - Only mc valid: mc_wready_o=1, ex_wready_o=0.
  - Both valid: grant the requester that is not last_grant.
  - last_grant updates only on a contended grant. Uncontended grants leave it unchanged.
  - Neither valid: both ready=0.
  - Exactly one transfer per cycle, never both.
- Write port, 1-cycle registered latency:
  - On a transfer in cycle N, reg_waddr_o/reg_wdata_o take the granted addr/data at the N+1 edge.
  - reg_wen_o=1 during cycle N+1 iff the granted addr != 0.
  - With no transfer, reg_wen_o=0; addr/data hold their previous values.
  - A write to x0 completes the handshake but produces no write enable.
- Scoreboard:
  - Set: mc_issue_i && mc_issue_rd_i!=0 sets pending[mc_issue_rd_i] at the next edge.
  - Clear: an mc transfer clears pending[mc_waddr_i] at the next edge.
  - Same rd set and cleared in the same cycle: set wins.
  - pending[0] is always 0.
  - An ex transfer never touches pending.
- Hazard:
  - hazard_o = (id_rs1_i!=0 && pending[id_rs1_i]) || (id_rs2_i!=0 && pending[id_rs2_i]) || (id_rd_i!=0 && pending[id_rd_i]).
  - Computed combinationally from registered pending only. There is no bypass of a same-cycle clear, so the stall releases the cycle after the mc write is accepted.
  - hazard_o=0 during reset.
- Precondition: decode never issues an mc instruction while hazard_o=1, so at most one outstanding mc write exists per rd.

Test Plan:
- Reset, then ex_wvalid=1, waddr=5, wdata=0x1234 -> ex_wready=1 same cycle; next cycle reg_wen=1, reg_waddr=5, reg_wdata=0x1234.
- ex and mc both valid for 3 consecutive cycles (ex rd=1/2/3, mc rd=4 held until accepted) -> grants ex, mc, ex; last_grant alternates; reg_wen high for 3 consecutive cycles.
- ex write to x0 with wdata=0xFFFF -> ex_wready=1; next cycle reg_wen=0.
- mc_issue rd=7; next cycle id_rs2=7 -> hazard=1; mc write rd=7 accepted in cycle N -> hazard=1 in N, 0 in N+1, reg_wen=1/waddr=7 in N+1.
- mc_issue rd=9 in the same cycle as an mc transfer to rd=9 -> pending[9]=1 afterward, hazard=1 for id_rs1=9; mc_issue rd=0 -> no pending bit set, hazard=0 for rs1=0.
- rst=0 asserted while pending[3]=1 and an mc transfer is accepted -> next cycle reg_wen=0, hazard=0 for rs1=3; the first contention after reset grants ex.
